display_dma: RTL

DISPLAY_DMA -- requirements
Module: display_dma

---
 rtl/display_pkg.sv | 29 ++
 rtl/pixel_unpack.sv | 71 +++++++
 rtl/display_dma.sv | 121 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// display_pkg: pixel-format encodings, FSM states and per-format sizing helpers
package display_pkg;

    typedef enum logic [1:0] {
        M_GRAY32 = 2'd0,
        M_RGB32  = 2'd1,
        M_GRAY8  = 2'd2,
        M_RSVD   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_RUN,
        S_DRAIN
    } state_t;

    // Pixels carried by one memory word; the reserved code unpacks as GRAY32.
    function automatic int unsigned ppw(input logic [1:0] m, input int unsigned mem_w);
        return (m == M_GRAY8) ? mem_w / 8 : mem_w / 32;
    endfunction

    // Memory words needed for one frame.
    function automatic int unsigned wpf(input logic [1:0] m, input int unsigned pixels,
                                        input int unsigned mem_w);
        return pixels / ppw(m, mem_w);
    endfunction

endpackage

// File: rtl/pixel_unpack.sv
// pixel_unpack: holds the word being unpacked and emits one pixel per unstalled cycle
//   mode_i      pixel format of the current frame
//   word_i/_v_i buffered next word offered by the fetcher
//   fifo_full_i downstream back-pressure; index and data_o hold while high
//   data_o      current pixel {R,G,B}; pix_valid_o means data_o is pending
//   load_o      word_i taken this cycle; last_o last pixel of the word written
module pixel_unpack
    import display_pkg::*;
#(
    parameter int MEM_W = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_i,
    input  logic [MEM_W-1:0] word_i,
    input  logic             word_v_i,
    input  logic             fifo_full_i,
    output logic [23:0]      data_o,
    output logic             pix_valid_o,
    output logic             load_o,
    output logic             last_o
);

    localparam int IW = $clog2(MEM_W / 8);

    logic [MEM_W-1:0] word_q, word_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [23:0]      lane;
    logic [7:0]       pbyte;
    logic             wen;

    assign lane        = 24'(word_q >> {idx_q, 5'd0});
    assign pbyte       = 8'(word_q >> {idx_q, 3'd0});
    assign wen         = valid_q & ~fifo_full_i;
    assign last_o      = wen & (idx_q == IW'(ppw(mode_i, MEM_W) - 1));
    // Reloading in the same cycle as the last pixel keeps WEN gap-free across words.
    assign load_o      = word_v_i & (~valid_q | last_o);
    assign pix_valid_o = valid_q;
    assign data_o      = (mode_i == M_GRAY8) ? {3{pbyte}} :
                         (mode_i == M_RGB32) ? lane : {3{lane[7:0]}};

    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load_o) begin
            word_d  = word_i;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (last_o) begin
            idx_d   = '0;
            valid_d = 1'b0;
        end else if (wen) begin
            idx_d   = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/display_dma.sv
// display_dma: fetches a frame from the memory arbiter and streams pixels into a FIFO
//   enable          run request, looked at only when idle or at frame end
//   mode/base_addr  frame format and start address, latched at frame start
//   data_rd, mem_ready_data, mem_valid_data, mem_data_addr  read-only arbiter port
//   data_wr, mem_rw_data  tied off (never writes)
//   fifo_full, data_out, WEN  pixel FIFO port
//   frame_done, busy      frame status
module display_dma
    import display_pkg::*;
#(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int MEM_W  = 256,
    parameter int ADDR_W = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [MEM_W-1:0]  data_rd,
    input  logic              mem_ready_data,
    output logic [MEM_W-1:0]  data_wr,
    output logic              mem_rw_data,
    output logic [ADDR_W-1:0] mem_data_addr,
    output logic              mem_valid_data,
    input  logic              fifo_full,
    output logic [23:0]       data_out,
    output logic              WEN,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned NPIX = H_RES * V_RES;
    localparam int          CW   = $clog2(NPIX + 1);

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [MEM_W-1:0]  buf_q, buf_d;
    logic              buf_v_q, buf_v_d;
    logic              cap, load, last, pix_valid, done, start;

    pixel_unpack #(.MEM_W(MEM_W)) u_unpack (
        .clk         (clk),
        .rst         (rst),
        .mode_i      (mode_q),
        .word_i      (buf_q),
        .word_v_i    (buf_v_q),
        .fifo_full_i (fifo_full),
        .data_o      (data_out),
        .pix_valid_o (pix_valid),
        .load_o      (load),
        .last_o      (last)
    );

    // Stray ready strobes with nothing outstanding are ignored.
    assign cap   = valid_q & mem_ready_data;
    // Every word is fetched in DRAIN, so an empty buffer means this is the frame's final pixel.
    assign done  = last & ~buf_v_q & (state_q == S_DRAIN);
    assign start = enable & ((state_q == S_IDLE) | done);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        buf_d   = buf_q;
        buf_v_d = buf_v_q;
        if (load) buf_v_d = 1'b0;
        // A read only issues with the buffer empty, so capture never collides with load.
        if (cap) begin
            valid_d = 1'b0;
            buf_d   = data_rd;
            buf_v_d = 1'b1;
            addr_d  = addr_q + ADDR_W'(MEM_W / 32);
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(wpf(mode_q, NPIX, MEM_W) - 1)) ? S_DRAIN : S_RUN;
        end
        if ((state_q == S_FETCH || state_q == S_RUN) && !valid_q && !buf_v_q) valid_d = 1'b1;
        if (done) state_d = S_IDLE;
        if (start) begin
            state_d = S_FETCH;
            mode_d  = mode;
            addr_d  = base_addr;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            buf_q   <= '0;
            buf_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            buf_q   <= buf_d;
            buf_v_q <= buf_v_d;
        end
    end

    assign data_wr        = '0;
    assign mem_rw_data    = 1'b0;
    assign mem_data_addr  = addr_q;
    assign mem_valid_data = valid_q;
    assign WEN            = pix_valid & ~fifo_full;
    assign frame_done     = done;
    assign busy           = (state_q != S_IDLE);

endmodule
